// File: rtl/msk_key_share_loader.sv
// Shared-key loader: gathers masked AES key columns into a 256*d-bit register
// and hands the complete sharing to the masked datapath, then zeroizes it.
module msk_key_share_loader #(
   parameter int d = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [32*d-1:0]   in_sh_col,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_mode,
   output logic [256*d-1:0]  out_sh_key,
   output logic              busy
);

   localparam int CW = 32 * d;

   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [1:0]     mode_q, mode_d;
   logic [CW-1:0]  col_q [8];
   logic           col_we;
   logic           clr;
   logic [1:0]     mode_eff;
   logic [2:0]     last_idx;

   // Mode that governs this beat: fresh on the first beat, latched after.
   always_comb begin
      mode_eff = (cnt_q == 3'd0) ? in_mode : mode_q;
   end

   // Index of the final beat for the governing key size.
   always_comb begin
      last_idx = 3'd7;
      unique case (1'b1)
         (mode_eff == 2'b00): last_idx = 3'd3;
         (mode_eff == 2'b01): last_idx = 3'd5;
         default:             last_idx = 3'd7;
      endcase
   end

   // Next-state and handshake logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      col_we    = 1'b0;
      clr       = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               col_we = 1'b1;
               if (cnt_q == 3'd0) mode_d = in_mode;
               if (cnt_q == last_idx) begin
                  state_d = FULL;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         FULL: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = LOAD;
               clr     = 1'b1;
               mode_d  = 2'b00;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Control state; abort behaves as a synchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= 3'd0;
         mode_q  <= 2'b00;
      end else if (abort) begin
         state_q <= LOAD;
         cnt_q   <= 3'd0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Column store: share-wise copy in, all-zero sharing on clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) col_q[i] <= '0;
      end else if (abort || clr) begin
         for (int i = 0; i < 8; i++) col_q[i] <= '0;
      end else if (col_we) begin
         for (int i = 0; i < 8; i++) begin
            if (cnt_q == 3'(i)) col_q[i] <= in_sh_col;
         end
      end
   end

   for (genvar k = 0; k < 8; k++) begin : g_out
      assign out_sh_key[CW*k +: CW] = col_q[k];
   end

   assign busy     = (state_q == LOAD) && (cnt_q != 3'd0);
   assign out_mode = (mode_q == 2'b11) ? 2'b10 : mode_q;

endmodule

// File: tb/tb_msk_key_share_loader.sv
// Directed bench for msk_key_share_loader (d=2): loads masked keys
// and checks unmasked columns, handshakes, abort and reset.
module tb_msk_key_share_loader;

   localparam int D  = 2;
   localparam int CW = 32 * D;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              abort = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        in_mode = 2'b00;
   logic [CW-1:0]     in_sh_col = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [1:0]        out_mode;
   logic [256*D-1:0]  out_sh_key;
   logic              busy;

   int n_run = 0;
   int n_fail = 0;
   int acc = 0;

   msk_key_share_loader #(.d(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mode    (in_mode),
      .in_sh_col  (in_sh_col),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mode   (out_mode),
      .out_sh_key (out_sh_key),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] shr(input logic [31:0] v,
                                         input logic [31:0] m);
      logic [CW-1:0] r;
      for (int b = 0; b < 32; b++) begin
         r[b*D]   = m[b];
         r[b*D+1] = v[b] ^ m[b];
      end
      return r;
   endfunction

   function automatic logic [31:0] unsh(input int k);
      logic [CW-1:0] c;
      logic [31:0]   r;
      c = out_sh_key[CW*k +: CW];
      for (int b = 0; b < 32; b++) r[b] = c[b*D] ^ c[b*D+1];
      return r;
   endfunction

   function automatic logic [63:0] raw(input int k);
      return out_sh_key[CW*k +: CW];
   endfunction

   function automatic logic [31:0] v128(input int k);
      return 32'h03020100 + 32'h04040404 * k;
   endfunction

   task automatic drive(input logic [1:0] m, input logic [31:0] v);
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = m;
      in_sh_col = shr(v, $urandom);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic handoff(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ov0"}, 64'(out_valid), 64'd0);
      chk({tag, "_ir1"}, 64'(in_ready), 64'd1);
      chk({tag, "_zero"}, 64'(|out_sh_key), 64'd0);
      chk({tag, "_md0"}, 64'(out_mode), 64'd0);
   endtask

   initial begin
      #1;
      chk("rst_ir", 64'(in_ready), 64'd1);
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mode", 64'(out_mode), 64'd0);
      chk("rst_key", 64'(|out_sh_key), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // AES-128, held by consumer
      for (int k = 0; k < 4; k++) drive(2'b00, v128(k));
      idle();
      chk("k128_ov", 64'(out_valid), 64'd1);
      chk("k128_ir", 64'(in_ready), 64'd0);
      chk("k128_busy", 64'(busy), 64'd0);
      chk("k128_mode", 64'(out_mode), 64'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("k128_c%0d", k),
                                      64'(unsh(k)), 64'(v128(k)));
      for (int k = 4; k < 8; k++) chk($sformatf("k128_z%0d", k),
                                      raw(k), 64'd0);
      idle();
      chk("k128_hold_ov", 64'(out_valid), 64'd1);
      chk("k128_hold_c3", 64'(unsh(3)), 64'h0F0E0D0C);
      handoff("k128_ho");

      // AES-256 back-to-back, consumer always ready
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) drive(2'b10, 32'hA5A50000 + k);
      @(negedge clk);
      in_sh_col = shr(32'h11111111, $urandom);
      chk("b2b_ov", 64'(out_valid), 64'd1);
      chk("b2b_ir0", 64'(in_ready), 64'd0);
      chk("b2b_mode", 64'(out_mode), 64'd2);
      chk("b2b_c0", 64'(unsh(0)), 64'hA5A50000);
      chk("b2b_c7", 64'(unsh(7)), 64'hA5A50007);
      @(negedge clk);
      chk("b2b_ir1", 64'(in_ready), 64'd1);
      chk("b2b_ov0", 64'(out_valid), 64'd0);
      chk("b2b_zero", 64'(|out_sh_key), 64'd0);
      idle();
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_next", 64'(unsh(0)), 64'h11111111);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("b2b_clr", 64'(busy), 64'd0);

      // AES-192, mode changes after first beat are ignored
      drive(2'b01, 32'hC0DE0000);
      for (int k = 1; k < 6; k++) drive(2'b10, 32'hC0DE0000 + k);
      idle();
      chk("k192_ov", 64'(out_valid), 64'd1);
      chk("k192_mode", 64'(out_mode), 64'd1);
      chk("k192_c5", 64'(unsh(5)), 64'hC0DE0005);
      chk("k192_z6", raw(6), 64'd0);
      chk("k192_z7", raw(7), 64'd0);
      handoff("k192_ho");

      // Mode 11 needs 8 beats, reported as 10
      for (int k = 0; k < 6; k++) drive(2'b11, 32'h3300 + k);
      idle();
      chk("m11_ov6", 64'(out_valid), 64'd0);
      chk("m11_busy", 64'(busy), 64'd1);
      for (int k = 6; k < 8; k++) drive(2'b00, 32'h3300 + k);
      idle();
      chk("m11_ov", 64'(out_valid), 64'd1);
      chk("m11_mode", 64'(out_mode), 64'd2);
      chk("m11_c7", 64'(unsh(7)), 64'h3307);
      handoff("m11_ho");

      // Abort mid-load, then a clean 128 key
      for (int k = 0; k < 3; k++) drive(2'b10, 32'hBAD00000 + k);
      @(negedge clk);
      in_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy", 64'(busy), 64'd0);
      chk("ab_ir", 64'(in_ready), 64'd1);
      chk("ab_zero", 64'(|out_sh_key), 64'd0);
      for (int k = 0; k < 4; k++) drive(2'b00, v128(k) ^ 32'hFFFF);
      idle();
      chk("ab_ov", 64'(out_valid), 64'd1);
      chk("ab_mode", 64'(out_mode), 64'd0);
      chk("ab_c2", 64'(unsh(2)), 64'(v128(2) ^ 32'hFFFF));
      for (int k = 4; k < 8; k++) chk($sformatf("ab_z%0d", k),
                                      raw(k), 64'd0);

      // Async reset while FULL
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rs_ov", 64'(out_valid), 64'd0);
      chk("rs_key", 64'(|out_sh_key), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Bubbles: in_valid every other cycle
      for (int k = 0; k < 8; k++) begin
         drive(2'b10, 32'h5A000000 + k);
         #1;
         if (in_valid && in_ready) acc++;
         @(negedge clk);
         in_valid  = 1'b0;
         in_sh_col = shr(32'hDEADBEEF, $urandom);
      end
      chk("bub_ov", 64'(out_valid), 64'd1);
      for (int k = 0; k < 3; k++) begin
         drive(2'b00, 32'hDEADBEEF);
         #1;
         if (in_valid && in_ready) acc++;
      end
      chk("bub_acc", 64'(acc), 64'd8);
      for (int k = 0; k < 8; k++) chk($sformatf("bub_c%0d", k),
                                      64'(unsh(k)), 64'(32'h5A000000 + k));
      idle();
      handoff("bub_ho");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
